piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in serial-out serializer that sits directly upstream of the team's 4-bit serial-in parallel-out shift register. It converts parallel words into a one-bit serial stream at one bit per clock. A valid/ready handshake on the parallel side and a one-word holding buffer allow back-to-back words to stream with no idle gap. Each serial bit carries a valid qualifier and each word's final bit carries an end-of-word strobe, so the downstream stage can frame words.

## Interface
- WIDTH, 4, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pd  in  WIDTH  parallel word; sampled only on an accept.
- pd_valid  in  1  upstream holds a word on pd.
- pd_ready  out  1  block can take a word this cycle; equals !hold_full and comes from a register only.
- so  out  1  serial data bit; forced to 0 when so_valid=0.
- so_valid  out  1  so carries a live bit this cycle.
- so_last  out  1  so is the final bit of the current word.
- busy  out  1  shift register or holding register is occupied.

## Operation
- Accept = pd_valid && pd_ready at a rising clk edge.
- States:
  - IDLE: shift register empty.
  - SHIFT: shift register holds a word; bit counter runs from 0 to WIDTH-1.
- IDLE + accept: pd loads straight into the shift register, bypassing the hold; go to SHIFT with count 0.
- SHIFT + accept: pd loads into the holding register; hold_full=1, so pd_ready=0.
- SHIFT, count=WIDTH-1:
  - If hold_full: the hold moves into the shift register, count goes to 0, hold_full clears, and the state stays SHIFT. No gap between words.
  - Else if an accept occurs in this same cycle: pd loads straight into the shift register (gapless).
  - Else: go to IDLE.
- Shifting:
  - MSB_FIRST=1: so = sreg[WIDTH-1]; the register shifts left with 0 filled in.
  - MSB_FIRST=0: so = sreg[0]; the register shifts right with 0 filled in.
- so_last = so_valid && (count == WIDTH-1).
- busy = (state == SHIFT) || hold_full.
- No accept is possible while hold_full=1. There is no overflow path.
- pd must not be sampled outside an accept; changes on pd at other times have no effect.
- Reset asserted mid-word: the word in flight and any held word are discarded and never resumed.

## Timing
- Reset values: so=0, so_valid=0, so_last=0, busy=0, pd_ready=1; state=IDLE, count=0, hold_full=0, sreg=0.
- Latency: the first bit of a word is on so in the cycle after the accept edge.
- Duration: a word occupies exactly WIDTH consecutive so_valid cycles.
- Throughput: 1 bit/clk sustained when upstream keeps pd_valid high.
- pd_ready rise: pd_ready returns to 1 in the cycle after the hold drains into the shift register.
- Outputs: so, so_valid, so_last and pd_ready are all registered; there are no combinational input-to-output paths.
- Bit counter width is $clog2(WIDTH); the count wraps from WIDTH-1 to 0 only on a reload.
- Reset release: deassertion of rst_n is synchronised externally. The first accept is permitted on the first clk edge after release.

## Structure
- Shared package piso_pkg holds:
  - the state enum {IDLE, SHIFT};
  - a localparam function computing the counter width from WIDTH.
- Single module. The shift register, hold buffer and counter are tightly coupled, so no sub-module is natural.
- Parameter checks: an elaboration-time assertion rejects WIDTH < 2 or WIDTH > 32.

## Test plan
- Single word, MSB first: reset, then accept pd=4'b1001 once. Required: so = 1,0,0,1 on the 4 cycles after accept; so_valid high for exactly 4 cycles; so_last only on the 4th; busy then drops and pd_ready stays 1.
- LSB first: MSB_FIRST=0, accept pd=4'b0001. Required: so = 1,0,0,0.
- Back-to-back: pd_valid held high with 4'hA, then 4'h5. Required: 8 contiguous so_valid cycles carrying 1,0,1,0,0,1,0,1; so_last on cycles 4 and 8.
- Backpressure: offer 4'hC, 4'h3 and 4'hF continuously. Required:
  - 4'hC goes to sreg and 4'h3 goes to the hold;
  - pd_ready=0 for 3 cycles;
  - 4'hF is accepted the cycle after 4'h3 enters sreg;
  - 12 gapless bits: 1100 0011 1111.
- Reset mid-word: accept 4'hF, assert rst_n=0 after 2 bits. Required: so, so_valid, so_last and busy drop to 0 immediately (asynchronously) and pd_ready=1. After release, accepting 4'h6 yields 0,1,1,0.
- Idle hygiene: pd toggles randomly with pd_valid=0 for 20 cycles. Required: so_valid=0, so=0, and no state change.

Source files
------------

// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in serial-out serializer.
//   piso_state_t : IDLE (shift register empty) / SHIFT (word being sent)
//   cnt_width()  : width of the bit counter for a given word width
// ---------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Counter must index bits 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage : piso_pkg

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Converts WIDTH-bit parallel words into a one-bit-per-clock serial stream.
// A one-word holding buffer lets back-to-back words stream without a gap.
//
// Parameters
//   WIDTH     : bits per word (2..32)
//   MSB_FIRST : 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   pd        in   parallel word, sampled only on accept
//   pd_valid  in   upstream offers a word
//   pd_ready  out  block can take a word (holding buffer empty)
//   so        out  serial data bit, 0 when so_valid is low
//   so_valid  out  so carries a live bit
//   so_last   out  so is the final bit of the current word
//   busy      out  shift register or holding buffer occupied
// ---------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pd,
    input  logic             pd_valid,
    output logic             pd_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("piso_serializer: WIDTH must lie in 2..32");
    end

    piso_state_t      state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    logic [WIDTH-1:0] sreg_shifted;
    logic             head;
    logic             accept;
    logic             at_last;

    // Bit order is fixed at elaboration: pick the output tap and shift direction.
    if (MSB_FIRST) begin : g_msb
        assign head         = sreg[WIDTH-1];
        assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
        assign head         = sreg[0];
        assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end

    // Every output below depends on registers only, never on pd/pd_valid.
    assign pd_ready = !hold_full;
    assign accept   = pd_valid && pd_ready;
    assign at_last  = (count == LAST);
    assign so_valid = (state == SHIFT);
    assign so       = so_valid && head;
    assign so_last  = so_valid && at_last;
    assign busy     = so_valid || hold_full;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            sreg      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Empty pipe: bypass the hold and start sending next cycle.
                        sreg  <= pd;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (at_last) begin
                        if (hold_full) begin
                            sreg      <= hold;
                            hold_full <= 1'b0;
                            count     <= '0;
                        end else if (accept) begin
                            sreg  <= pd;
                            count <= '0;
                        end else begin
                            // Shifting out the last bit also clears sreg for IDLE.
                            sreg  <= sreg_shifted;
                            state <= IDLE;
                        end
                    end else begin
                        sreg  <= sreg_shifted;
                        count <= count + CW'(1);
                        if (accept) begin
                            hold      <= pd;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Drives one MSB-first and one LSB-first serializer (WIDTH=4) from the same
// parallel stimulus. Expected outputs come from a table of hand-derived
// vectors plus a reference model that keeps the not-yet-sent bits of all
// accepted words in a queue: the front entry is what must be on so, and a
// word can be taken whenever no more than one word's worth of bits is queued.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 4;

    typedef struct packed {
        logic b;
        logic last;
    } sbit_t;

    typedef struct {
        logic [W-1:0] pd;
        logic         v;
        logic         so_m;
        logic         so_l;
        logic         sv;
        logic         sl;
        logic         rdy;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] pd;
    logic         pd_valid;

    logic rdy_m, so_m, sv_m, sl_m, busy_m;
    logic rdy_l, so_l, sv_l, sl_l, busy_l;

    int n_tests = 0;
    int n_fail  = 0;

    sbit_t qm[$];
    sbit_t ql[$];
    vec_t  vecs[$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk      (clk),
        .rst_n    (rst_n),
        .pd       (pd),
        .pd_valid (pd_valid),
        .pd_ready (rdy_m),
        .so       (so_m),
        .so_valid (sv_m),
        .so_last  (sl_m),
        .busy     (busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .pd       (pd),
        .pd_valid (pd_valid),
        .pd_ready (rdy_l),
        .so       (so_l),
        .so_valid (sv_l),
        .so_last  (sl_l),
        .busy     (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input sbit_t front, input int sz,
                              input logic so, input logic sv, input logic sl,
                              input logic rdy, input logic bsy);
        logic ev;
        ev = (sz > 0);
        check({tag, "_so_valid"}, 32'(sv), 32'(ev));
        check({tag, "_so"},       32'(so), 32'(ev ? front.b : 1'b0));
        check({tag, "_so_last"},  32'(sl), 32'(ev ? front.last : 1'b0));
        check({tag, "_busy"},     32'(bsy), 32'(ev));
        check({tag, "_pd_ready"}, 32'(rdy), 32'(sz <= W));
    endtask

    task automatic check_model();
        sbit_t fm, fl;
        fm = (qm.size() > 0) ? qm[0] : '0;
        fl = (ql.size() > 0) ? ql[0] : '0;
        check_inst("model_msb", fm, qm.size(), so_m, sv_m, sl_m, rdy_m, busy_m);
        check_inst("model_lsb", fl, ql.size(), so_l, sv_l, sl_l, rdy_l, busy_l);
    endtask

    task automatic model_edge(input logic [W-1:0] d, input logic acc);
        if (qm.size() != 0) void'(qm.pop_front());
        if (ql.size() != 0) void'(ql.pop_front());
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                qm.push_back('{b: d[W-1-i], last: (i == W-1)});
                ql.push_back('{b: d[i],     last: (i == W-1)});
            end
        end
    endtask

    // Called at a falling edge: check current outputs, drive inputs, clock once.
    task automatic step(input logic [W-1:0] d, input logic v);
        logic acc;
        check_model();
        pd       = d;
        pd_valid = v;
        acc      = v && (qm.size() <= W);
        @(posedge clk);
        model_edge(d, acc);
        @(negedge clk);
    endtask

    task automatic add_vec(input logic [W-1:0] d, input logic v, input logic som,
                           input logic sol, input logic sv, input logic sl, input logic rdy);
        vecs.push_back('{pd: d, v: v, so_m: som, so_l: sol, sv: sv, sl: sl, rdy: rdy});
    endtask

    initial begin
        logic [3:0] exp6;

        // pd, valid | so(msb), so(lsb), so_valid, so_last(msb), pd_ready
        // single word 4'b1001
        add_vec(4'h9, 1, 0, 0, 0, 0, 1);
        add_vec(4'h0, 0, 1, 1, 1, 0, 1);
        add_vec(4'h0, 0, 0, 0, 1, 0, 1);
        add_vec(4'h0, 0, 0, 0, 1, 0, 1);
        add_vec(4'h0, 0, 1, 1, 1, 1, 1);
        add_vec(4'h0, 0, 0, 0, 0, 0, 1);
        // single word 4'b0001 (lsb instance sends 1,0,0,0)
        add_vec(4'h1, 1, 0, 0, 0, 0, 1);
        add_vec(4'h0, 0, 0, 1, 1, 0, 1);
        add_vec(4'h0, 0, 0, 0, 1, 0, 1);
        add_vec(4'h0, 0, 0, 0, 1, 0, 1);
        add_vec(4'h0, 0, 1, 0, 1, 1, 1);
        add_vec(4'h0, 0, 0, 0, 0, 0, 1);
        // back-to-back 4'hA then 4'h5
        add_vec(4'hA, 1, 0, 0, 0, 0, 1);
        add_vec(4'h5, 1, 1, 0, 1, 0, 1);
        add_vec(4'h0, 0, 0, 1, 1, 0, 0);
        add_vec(4'h0, 0, 1, 0, 1, 0, 0);
        add_vec(4'h0, 0, 0, 1, 1, 1, 0);
        add_vec(4'h0, 0, 0, 1, 1, 0, 1);
        add_vec(4'h0, 0, 1, 0, 1, 0, 1);
        add_vec(4'h0, 0, 0, 1, 1, 0, 1);
        add_vec(4'h0, 0, 1, 0, 1, 1, 1);
        add_vec(4'h0, 0, 0, 0, 0, 0, 1);
        // backpressure: 4'hC, 4'h3, 4'hF offered continuously
        add_vec(4'hC, 1, 0, 0, 0, 0, 1);
        add_vec(4'h3, 1, 1, 0, 1, 0, 1);
        add_vec(4'hF, 1, 1, 0, 1, 0, 0);
        add_vec(4'hF, 1, 0, 1, 1, 0, 0);
        add_vec(4'hF, 1, 0, 1, 1, 1, 0);
        add_vec(4'hF, 1, 0, 1, 1, 0, 1);
        add_vec(4'h0, 0, 0, 1, 1, 0, 0);
        add_vec(4'h0, 0, 1, 0, 1, 0, 0);
        add_vec(4'h0, 0, 1, 0, 1, 1, 0);
        add_vec(4'h0, 0, 1, 1, 1, 0, 1);
        add_vec(4'h0, 0, 1, 1, 1, 0, 1);
        add_vec(4'h0, 0, 1, 1, 1, 0, 1);
        add_vec(4'h0, 0, 1, 1, 1, 1, 1);
        add_vec(4'h0, 0, 0, 0, 0, 0, 1);

        rst_n    = 1'b0;
        pd       = '0;
        pd_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_so_m", 32'(so_m), 0);
        check("rst_so_valid_m", 32'(sv_m), 0);
        check("rst_so_last_m", 32'(sl_m), 0);
        check("rst_busy_m", 32'(busy_m), 0);
        check("rst_pd_ready_m", 32'(rdy_m), 1);
        check("rst_so_valid_l", 32'(sv_l), 0);
        check("rst_pd_ready_l", 32'(rdy_l), 1);
        rst_n = 1'b1;

        // Table-driven directed sequences
        foreach (vecs[i]) begin
            check($sformatf("vec%0d_so_msb", i), 32'(so_m), 32'(vecs[i].so_m));
            check($sformatf("vec%0d_so_lsb", i), 32'(so_l), 32'(vecs[i].so_l));
            check($sformatf("vec%0d_so_valid_msb", i), 32'(sv_m), 32'(vecs[i].sv));
            check($sformatf("vec%0d_so_valid_lsb", i), 32'(sv_l), 32'(vecs[i].sv));
            check($sformatf("vec%0d_so_last", i), 32'(sl_m), 32'(vecs[i].sl));
            check($sformatf("vec%0d_pd_ready", i), 32'(rdy_m), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_busy", i), 32'(busy_m), 32'(vecs[i].sv));
            step(vecs[i].pd, vecs[i].v);
        end

        // Reset in the middle of a word
        step(4'hF, 1'b1);
        step(4'h0, 1'b0);
        check("midrst_pre_so_valid", 32'(sv_m), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_so_m", 32'(so_m), 0);
        check("midrst_so_valid_m", 32'(sv_m), 0);
        check("midrst_so_last_m", 32'(sl_m), 0);
        check("midrst_busy_m", 32'(busy_m), 0);
        check("midrst_pd_ready_m", 32'(rdy_m), 1);
        check("midrst_so_valid_l", 32'(sv_l), 0);
        check("midrst_busy_l", 32'(busy_l), 0);
        qm.delete();
        ql.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_hold_so_valid", 32'(sv_m), 0);
        rst_n = 1'b1;
        step(4'h6, 1'b1);
        exp6 = 4'b0110;
        for (int i = 0; i < W; i++) begin
            check($sformatf("after_rst_bit%0d_msb", i), 32'(so_m), 32'(exp6[W-1-i]));
            check($sformatf("after_rst_bit%0d_lsb", i), 32'(so_l), 32'(exp6[i]));
            step(4'h0, 1'b0);
        end
        check("after_rst_idle", 32'(sv_m), 0);

        // Idle hygiene: pd wiggles with pd_valid low
        for (int i = 0; i < 20; i++) begin
            step(4'($urandom), 1'b0);
            check($sformatf("idle%0d_so", i), 32'(so_m | so_l), 0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            step(4'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3 * W; i++) begin
            step(4'($urandom), 1'b0);
        end
        check_model();
        check("final_idle", 32'(busy_m | busy_l), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_piso_serializer
